reg_file_param: RTL and testbench
=================================

REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter: XLEN, 32, data width of each register in bits.
REQ-002 Parameter: NREGS, 32, number of registers; power of two, >= 2.
REQ-003 Parameter: AW, $clog2(NREGS), address width; derived, not overridden.
REQ-004 Parameter: ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes.
REQ-005 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-006 Port: rst  input  1  reset; synchronous, active-high.
REQ-007 Port: clr  input  1  request to re-run the clear sweep without reset.
REQ-008 Port: we  input  1  write enable.
REQ-009 Port: waddr  input  AW  write address.
REQ-010 Port: wdata  input  XLEN  write data.
REQ-011 Port: re  input  1  read enable; updates rd1/rd2.
REQ-012 Port: ra1  input  AW  read address, port 1.
REQ-013 Port: ra2  input  AW  read address, port 2.
REQ-014 Port: rd1  output  XLEN  registered read data, port 1.
REQ-015 Port: rd2  output  XLEN  registered read data, port 2.
REQ-016 Port: ready  output  1  high when in RUN; accesses accepted.

Function
REQ-017 Storage SHALL be NREGS x XLEN, one write port and two independent read ports.
REQ-018 FSM SHALL have states INIT and RUN, with a clear counter cnt of AW bits.
REQ-019 INIT: each cycle writes 0 to mem[cnt] and increments cnt; we, re and all addresses ignored.
REQ-020 INIT -> RUN on the edge that clears mem[NREGS-1]; ready goes 1 on that same edge.
REQ-021 The sweep SHALL take exactly NREGS cycles from the first INIT cycle to ready=1.
REQ-022 RUN -> INIT when clr=1 at an edge: cnt=0, ready=0, rd1=rd2=0; the write and read in that cycle are dropped.
REQ-023 clr=1 during INIT SHALL restart the sweep at cnt=0.
REQ-024 RUN write: we=1 -> mem[waddr]<=wdata at the edge, except waddr=0 with ZERO_REG=1 (dropped).
REQ-025 RUN read: re=1 -> rd1<=value(ra1), rd2<=value(ra2) at the edge, giving 1-cycle latency.
REQ-026 re=0 SHALL hold rd1/rd2 at their previous values.
REQ-027 Write-first bypass: same-cycle we=1, re=1 and waddr==raN -> rdN<=wdata, not the old contents.
REQ-028 With ZERO_REG=1, a read of address 0 SHALL return 0, even under a bypass match.
REQ-029 Both ports reading the same address SHALL return identical data.
REQ-030 No combinational path from any input to rd1, rd2 or ready.

Reset
REQ-031 rst=1 at an edge: state=INIT, cnt=0, ready=0, rd1=0, rd2=0; memory contents cleared by the following sweep.
REQ-032 rst SHALL take priority over clr, we and re.
REQ-033 rst asserted mid-sweep or in RUN SHALL restart the sweep from cnt=0.
REQ-034 rst held high SHALL keep cnt=0 and ready=0; the sweep starts on the first edge with rst=0.

Verification
REQ-035 Defaults: pulse rst 1 cycle -> ready=0 for exactly 32 edges, then 1; reads of all 32 addresses return 0.
REQ-036 RUN: write 0xDEADBEEF to x5, next cycle re with ra1=5, ra2=0 -> after 1 edge rd1=0xDEADBEEF, rd2=0.
REQ-037 Same cycle: we=1, waddr=7, wdata=0x12345678, re=1, ra1=ra2=7 -> rd1=rd2=0x12345678 after that edge.
REQ-038 Write 0xFFFFFFFF to x0, read ra1=0 -> rd1=0; repeat with ZERO_REG=0 -> rd1=0xFFFFFFFF.
REQ-039 Fill x1..x31 with nonzero data, assert clr mid-RUN -> ready=0 for 32 edges, rd1=rd2=0, then all reads 0.
REQ-040 XLEN=16, NREGS=8: assert rst at sweep cycle 4 -> ready rises 8 edges after rst drops; re=0 holds rd1/rd2 across writes.

Source files
------------

// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
//   Parameterised register file: NREGS x XLEN storage, one write port and two
//   registered read ports with write-first bypass. After reset (or a clr
//   request) a clear sweep zeroes every entry one per cycle; accesses are
//   accepted only once the sweep completes and ready is high.
//
// Parameters
//   XLEN     data width of each register
//   NREGS    number of registers (power of two, >= 2)
//   AW       address width, derived from NREGS
//   ZERO_REG 1: register 0 reads as zero and ignores writes
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset, highest priority
//   clr        restart the clear sweep without reset
//   we/waddr/wdata   write port
//   re/ra1/ra2       read enable and read addresses
//   rd1/rd2    registered read data (1-cycle latency)
//   ready      high while in RUN
// ---------------------------------------------------------------------------
module reg_file_param #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            re,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            ready
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_cnt;
    logic [XLEN-1:0] r_mem [NREGS];
    logic [XLEN-1:0] r_rd1;
    logic [XLEN-1:0] r_rd2;

    logic            w_run;
    logic            w_sweep_wr;
    logic            w_run_wr;
    logic            w_rd_upd;
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_addr;
    logic [XLEN-1:0] w_mem_data;
    logic [XLEN-1:0] w_rv1;
    logic [XLEN-1:0] w_rv2;

    // Value a read port captures: forced zero for register 0 (when enabled),
    // otherwise the same-cycle write data on an address match, else storage.
    function automatic logic [XLEN-1:0] f_read(
        input logic [AW-1:0]   a,
        input logic [XLEN-1:0] stored,
        input logic            byp_en,
        input logic [AW-1:0]   wa,
        input logic [XLEN-1:0] wd
    );
        if ((ZERO_REG != 0) && (a == '0))
            return '0;
        else if (byp_en && (wa == a))
            return wd;
        else
            return stored;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_INIT;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic: the sweep finishes on the edge that clears the last
    // entry; clr from either state (re)starts the sweep.
    always_comb begin
        w_state_nxt = r_state;
        if (clr)
            w_state_nxt = ST_INIT;
        else if ((r_state == ST_INIT) && (r_cnt == LAST_ADDR))
            w_state_nxt = ST_RUN;
    end

    // Output / enable decode. ready depends only on registered state.
    always_comb begin
        w_run      = (r_state == ST_RUN);
        ready      = w_run;
        w_sweep_wr = (r_state == ST_INIT) && !rst && !clr;
        w_run_wr   = w_run && !rst && !clr && we &&
                     !((ZERO_REG != 0) && (waddr == '0));
        w_rd_upd   = w_run && !rst && !clr && re;
    end

    // Clear counter; wraps back to 0 as the sweep completes.
    always_ff @(posedge clk) begin
        if (rst || clr)
            r_cnt <= '0;
        else if (r_state == ST_INIT)
            r_cnt <= r_cnt + 1'b1;
    end

    // Single physical write port shared by the sweep and normal writes.
    always_comb begin
        w_mem_we   = w_sweep_wr || w_run_wr;
        w_mem_addr = w_sweep_wr ? r_cnt : waddr;
        w_mem_data = w_sweep_wr ? '0 : wdata;
    end

    always_ff @(posedge clk) begin
        if (w_mem_we)
            r_mem[w_mem_addr] <= w_mem_data;
    end

    always_comb begin
        w_rv1 = f_read(ra1, r_mem[ra1], w_run_wr, waddr, wdata);
        w_rv2 = f_read(ra2, r_mem[ra2], w_run_wr, waddr, wdata);
    end

    // Read data registers: zeroed by rst/clr, held while re is low.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_rd1 <= '0;
            r_rd2 <= '0;
        end else if (w_rd_upd) begin
            r_rd1 <= w_rv1;
            r_rd2 <= w_rv2;
        end
    end

    assign rd1 = r_rd1;
    assign rd2 = r_rd2;

endmodule

// File: tb/tb_reg_file_param.sv
module tb_reg_file_param;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Group AB: defaults (ZERO_REG=1) and ZERO_REG=0 share the stimulus
    logic        rst, clr, we, re;
    logic [4:0]  waddr, ra1, ra2;
    logic [31:0] wdata;
    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic        ready_a, ready_b;

    // Group C: XLEN=16, NREGS=8
    logic        c_rst, c_clr, c_we, c_re;
    logic [2:0]  c_waddr, c_ra1, c_ra2;
    logic [15:0] c_wdata;
    logic [15:0] rd1_c, rd2_c;
    logic        ready_c;

    reg_file_param u_a (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a), .ready(ready_a)
    );

    reg_file_param #(.ZERO_REG(0)) u_b (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b), .ready(ready_b)
    );

    reg_file_param #(.XLEN(16), .NREGS(8)) u_c (
        .clk(clk), .rst(c_rst), .clr(c_clr), .we(c_we), .waddr(c_waddr), .wdata(c_wdata),
        .re(c_re), .ra1(c_ra1), .ra2(c_ra2), .rd1(rd1_c), .rd2(rd2_c), .ready(ready_c)
    );

    // Reference model: storage arrays, edges remaining until ready, expected outputs
    logic [31:0] mem_a [32];
    logic [31:0] mem_b [32];
    logic [15:0] mem_c [8];
    int          busy_ab, busy_c;
    logic [31:0] e1_a, e2_a, e1_b, e2_b;
    logic [15:0] e1_c, e2_c;

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] rv(input logic [31:0] stored, input int a, input bit zr,
                                       input logic w, input int wa, input logic [31:0] wd);
        if (zr && a == 0) return 32'h0;
        if (w && wa == a && !(zr && wa == 0)) return wd;
        return stored;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ":ready_a"}, {31'b0, ready_a}, {31'b0, busy_ab == 0});
        check({tag, ":ready_b"}, {31'b0, ready_b}, {31'b0, busy_ab == 0});
        check({tag, ":rd1_a"}, rd1_a, e1_a);
        check({tag, ":rd2_a"}, rd2_a, e2_a);
        check({tag, ":rd1_b"}, rd1_b, e1_b);
        check({tag, ":rd2_b"}, rd2_b, e2_b);
        check({tag, ":ready_c"}, {31'b0, ready_c}, {31'b0, busy_c == 0});
        check({tag, ":rd1_c"}, {16'b0, rd1_c}, {16'b0, e1_c});
        check({tag, ":rd2_c"}, {16'b0, rd2_c}, {16'b0, e2_c});
    endtask

    // Advance one clock edge, updating the model from the inputs applied for it
    task automatic tick();
        if (rst) begin
            busy_ab = 32; e1_a = '0; e2_a = '0; e1_b = '0; e2_b = '0;
            foreach (mem_a[i]) begin mem_a[i] = '0; mem_b[i] = '0; end
        end else if (busy_ab > 0) begin
            if (clr) busy_ab = 32; else busy_ab--;
        end else if (clr) begin
            busy_ab = 32; e1_a = '0; e2_a = '0; e1_b = '0; e2_b = '0;
            foreach (mem_a[i]) begin mem_a[i] = '0; mem_b[i] = '0; end
        end else begin
            if (re) begin
                e1_a = rv(mem_a[ra1], ra1, 1'b1, we, waddr, wdata);
                e2_a = rv(mem_a[ra2], ra2, 1'b1, we, waddr, wdata);
                e1_b = rv(mem_b[ra1], ra1, 1'b0, we, waddr, wdata);
                e2_b = rv(mem_b[ra2], ra2, 1'b0, we, waddr, wdata);
            end
            if (we && waddr != 0) mem_a[waddr] = wdata;
            if (we) mem_b[waddr] = wdata;
        end

        if (c_rst) begin
            busy_c = 8; e1_c = '0; e2_c = '0;
            foreach (mem_c[i]) mem_c[i] = '0;
        end else if (busy_c > 0) begin
            if (c_clr) busy_c = 8; else busy_c--;
        end else if (c_clr) begin
            busy_c = 8; e1_c = '0; e2_c = '0;
            foreach (mem_c[i]) mem_c[i] = '0;
        end else begin
            if (c_re) begin
                e1_c = 16'(rv({16'b0, mem_c[c_ra1]}, c_ra1, 1'b1, c_we, c_waddr, {16'b0, c_wdata}));
                e2_c = 16'(rv({16'b0, mem_c[c_ra2]}, c_ra2, 1'b1, c_we, c_waddr, {16'b0, c_wdata}));
            end
            if (c_we && c_waddr != 0) mem_c[c_waddr] = c_wdata;
        end

        @(posedge clk);
        #1;
    endtask

    task automatic idle_ab();
        rst = 0; clr = 0; we = 0; re = 0; waddr = '0; wdata = '0; ra1 = '0; ra2 = '0;
    endtask

    initial begin
        int n;
        foreach (mem_a[i]) begin mem_a[i] = '0; mem_b[i] = '0; end
        foreach (mem_c[i]) mem_c[i] = '0;
        busy_ab = 32; busy_c = 8;
        e1_a = '0; e2_a = '0; e1_b = '0; e2_b = '0; e1_c = '0; e2_c = '0;
        idle_ab();
        c_clr = 0; c_we = 0; c_re = 0; c_waddr = '0; c_wdata = '0; c_ra1 = '0; c_ra2 = '0;

        // Reset pulse; group C stays in reset throughout the AB phase
        rst = 1; c_rst = 1;
        #2;
        tick();
        check_all("reset");
        rst = 0;

        // Sweep length after reset
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick(); n++; check_all("sweep");
            if (ready_a) break;
        end
        check("sweep_len", n, 32);

        // Every address reads zero after the sweep
        re = 1;
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a); ra2 = 5'(31 - a);
            tick(); check_all("read_zero");
            check("zero_rd1", rd1_a, 32'h0);
        end

        // Write x5, then read x5 / x0
        idle_ab(); we = 1; waddr = 5; wdata = 32'hDEADBEEF;
        tick(); check_all("wr_x5");
        idle_ab(); re = 1; ra1 = 5; ra2 = 0;
        tick(); check_all("rd_x5");
        check("x5_rd1", rd1_a, 32'hDEADBEEF);
        check("x5_rd2", rd2_a, 32'h0);

        // Same-cycle write/read bypass on both ports
        idle_ab(); we = 1; waddr = 7; wdata = 32'h12345678; re = 1; ra1 = 7; ra2 = 7;
        tick(); check_all("bypass");
        check("byp_rd1", rd1_a, 32'h12345678);
        check("byp_rd2", rd2_a, 32'h12345678);

        // Register 0 behaviour with and without ZERO_REG
        idle_ab(); we = 1; waddr = 0; wdata = 32'hFFFFFFFF;
        tick(); check_all("wr_x0");
        idle_ab(); re = 1; ra1 = 0; ra2 = 0;
        tick(); check_all("rd_x0");
        check("x0_zr1", rd1_a, 32'h0);
        check("x0_zr0", rd1_b, 32'hFFFFFFFF);
        idle_ab(); we = 1; waddr = 0; wdata = 32'hA5A5A5A5; re = 1; ra1 = 0; ra2 = 0;
        tick(); check_all("byp_x0");
        check("byp_x0_zr1", rd2_a, 32'h0);
        check("byp_x0_zr0", rd2_b, 32'hA5A5A5A5);

        // Randomised traffic with occasional clr and rst
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 249) == 0);
            clr   = ($urandom_range(0, 79) == 0);
            we    = 1'($urandom);
            re    = 1'($urandom);
            waddr = 5'($urandom);
            ra1   = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            ra2   = ($urandom_range(0, 3) == 0) ? ra1 : 5'($urandom);
            wdata = $urandom;
            tick(); check_all("random");
        end

        // Back to RUN, fill x1..x31, then clr mid-RUN
        idle_ab();
        for (int i = 0; i < 40 && busy_ab != 0; i++) begin
            tick(); check_all("settle");
        end
        for (int a = 1; a < 32; a++) begin
            we = 1; waddr = 5'(a); wdata = $urandom | 32'h1;
            tick(); check_all("fill");
        end
        idle_ab(); re = 1; ra1 = 3; ra2 = 9;
        tick(); check_all("pre_clr");
        clr = 1; we = 1; waddr = 4; wdata = 32'h55AA55AA; re = 1;
        tick(); check_all("clr");
        check("clr_ready", {31'b0, ready_a}, 32'h0);
        check("clr_rd1", rd1_a, 32'h0);
        check("clr_rd2", rd2_a, 32'h0);
        idle_ab();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick(); n++; check_all("clr_sweep");
            if (ready_a) break;
        end
        check("clr_sweep_len", n, 32);
        re = 1;
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a); ra2 = 5'(a);
            tick(); check_all("clr_read");
            check("clr_zero_b", rd1_b, 32'h0);
        end
        idle_ab();

        // Group C: reset dropped, re-asserted at sweep cycle 4
        c_rst = 0;
        for (int i = 0; i < 4; i++) begin
            tick(); check_all("c_sweep");
        end
        c_rst = 1;
        tick(); check_all("c_rst_mid");
        c_rst = 0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick(); n++; check_all("c_sweep2");
            if (ready_c) break;
        end
        check("c_sweep_len", n, 8);

        // Write then read, then hold read data with re=0 across writes
        c_we = 1; c_waddr = 2; c_wdata = 16'hBEEF;
        tick(); check_all("c_wr");
        c_we = 0; c_re = 1; c_ra1 = 2; c_ra2 = 0;
        tick(); check_all("c_rd");
        check("c_rd1", {16'b0, rd1_c}, 32'h0000BEEF);
        c_re = 0; c_we = 1;
        for (int i = 0; i < 6; i++) begin
            c_waddr = 3'(i % 3 + 1); c_wdata = 16'($urandom);
            c_ra1 = c_waddr; c_ra2 = c_waddr;
            tick(); check_all("c_hold");
            check("c_hold_rd1", {16'b0, rd1_c}, 32'h0000BEEF);
        end

        // Randomised traffic on group C
        for (int i = 0; i < 200; i++) begin
            c_clr   = ($urandom_range(0, 59) == 0);
            c_we    = 1'($urandom);
            c_re    = 1'($urandom);
            c_waddr = 3'($urandom);
            c_ra1   = ($urandom_range(0, 2) == 0) ? c_waddr : 3'($urandom);
            c_ra2   = 3'($urandom);
            c_wdata = 16'($urandom);
            tick(); check_all("c_random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
